// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } state_e;

    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
    localparam int          DEFAULT_MEM_BYTES = 64;
    localparam int          BEATS             = 4;

endpackage

// File: rtl/inst_byte_ram.sv
// Byte-wide instruction store: one synchronous write port, one combinational read port.
module inst_byte_ram
    import inst_fetch_pkg::*;
#(
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
    parameter int AW        = 6
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [MEM_BYTES];

    // Contents deliberately survive reset so a loaded program is retained.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: range-checks a request, reads four bytes one per cycle
// and returns them as a big-endian word, holding the response until it is accepted.
module inst_fetch_responder
    import inst_fetch_pkg::*;
#(
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES,
    parameter int LOAD_AW   = 6
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_address,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [31:0]        resp_instruction,
    output logic               resp_error,
    input  logic               load_en,
    input  logic [LOAD_AW-1:0] load_address,
    input  logic [7:0]         load_byte,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [1:0]         beat_q, beat_d;
    logic [LOAD_AW-1:0] addr_q, addr_d;
    // Only the first three bytes need storing; the fourth arrives on the final beat.
    logic [23:0]        shift_q, shift_d;
    logic [31:0]        resp_instr_q, resp_instr_d;
    logic               resp_err_q, resp_err_d;

    logic               ram_we;
    logic [LOAD_AW-1:0] rd_addr;
    logic [7:0]         rd_byte;
    logic               misaligned;
    logic               out_of_range;

    assign rd_addr      = addr_q + LOAD_AW'(beat_q);
    assign misaligned   = |req_address[1:0];
    assign out_of_range = req_address >= 32'(MEM_BYTES);

    assign req_ready        = reset_n && (state_q == IDLE) && !load_en;
    assign resp_valid       = (state_q == RESP);
    assign busy             = (state_q != IDLE);
    assign resp_instruction = resp_instr_q;
    assign resp_error       = resp_err_q;

    inst_byte_ram #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (LOAD_AW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (ram_we),
        .wr_addr (load_address),
        .wr_data (load_byte),
        .rd_addr (rd_addr),
        .rd_data (rd_byte)
    );

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        addr_d       = addr_q;
        shift_d      = shift_q;
        resp_instr_d = resp_instr_q;
        resp_err_d   = resp_err_q;
        ram_we       = 1'b0;

        case (state_q)
            IDLE: begin
                ram_we = load_en;
                if (req_valid && req_ready) begin
                    addr_d = req_address[LOAD_AW-1:0];
                    if (misaligned || out_of_range) begin
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_instr_d = NOP_WORD;
                    end else begin
                        state_d = READ;
                        beat_d  = 2'd0;
                        shift_d = 24'h0;
                    end
                end
            end
            READ: begin
                shift_d = {shift_q[15:0], rd_byte};
                beat_d  = beat_q + 2'd1;
                if (beat_q == 2'(BEATS - 1)) begin
                    state_d      = RESP;
                    resp_instr_d = {shift_q, rd_byte};
                    resp_err_d   = 1'b0;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            beat_q       <= 2'd0;
            addr_q       <= '0;
            shift_q      <= 24'h0;
            resp_instr_q <= NOP_WORD;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            addr_q       <= addr_d;
            shift_q      <= shift_d;
            resp_instr_q <= resp_instr_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Self-checking bench for inst_fetch_responder: directed scenarios plus randomized
// fetches compared against a byte-array reference of the instruction memory.
module tb_inst_fetch_responder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_address;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instruction;
    logic        resp_error;
    logic        load_en;
    logic [5:0]  load_address;
    logic [7:0]  load_byte;
    logic        busy;

    logic [7:0]  mem_model [64];
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    inst_fetch_responder #(.MEM_BYTES(64), .LOAD_AW(6)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_address      (req_address),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_instruction (resp_instruction),
        .resp_error       (resp_error),
        .load_en          (load_en),
        .load_address     (load_address),
        .load_byte        (load_byte),
        .busy             (busy)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [5:0] a, input logic [7:0] b);
        load_en      = 1'b1;
        load_address = a;
        load_byte    = b;
        step();
        load_en      = 1'b0;
        mem_model[a] = b;
        $display("load  mem[%0d] = %02h", a, b);
    endtask

    function automatic logic model_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 64);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int i;
        if (model_err(a)) return 32'h0;
        i = int'(a);
        return {mem_model[i], mem_model[i+1], mem_model[i+2], mem_model[i+3]};
    endfunction

    // Handshakes a request and counts edges from the accepting edge until resp_valid.
    task automatic issue(input logic [31:0] a, output int lat);
        int n;
        req_address = a;
        req_valid   = 1'b1;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
        $display("fetch addr=%08h lat=%0d instr=%08h err=%0b", a, lat, resp_instruction, resp_error);
    endtask

    task automatic complete();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 1'b1;
        req_address = 32'h0;
        step();
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%0b exp=0", resp_valid); end
        checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL reset_resp_error got=%0b exp=0", resp_error); end
        checks++; if (resp_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got=%08h exp=00000000", resp_instruction); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%0b exp=0", req_ready); end
        req_valid = 1'b0;
        reset_n   = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got=%0b exp=1", req_ready); end
        step();
        $display("reset done");
    endtask

    task automatic test_program();
        logic [7:0] prog [8];
        int lat;
        prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        for (int i = 0; i < 8; i++) load(6'(i), prog[i]);
        issue(32'd0, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL prog0_latency got=%0d exp=5", lat); end
        checks++; if (resp_instruction !== 32'h20080005) begin errors++; $display("FAIL prog0_instr got=%08h exp=20080005", resp_instruction); end
        checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL prog0_err got=%0b exp=0", resp_error); end
        complete();
        issue(32'd4, lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL prog4_latency got=%0d exp=5", lat); end
        checks++; if (resp_instruction !== 32'h8C090004) begin errors++; $display("FAIL prog4_instr got=%08h exp=8c090004", resp_instruction); end
        complete();
    endtask

    task automatic test_misaligned();
        int lat;
        issue(32'h2, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL misalign_latency got=%0d exp=1", lat); end
        checks++; if (resp_error !== 1'b1) begin errors++; $display("FAIL misalign_err got=%0b exp=1", resp_error); end
        checks++; if (resp_instruction !== 32'h0) begin errors++; $display("FAIL misalign_instr got=%08h exp=00000000", resp_instruction); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL misalign_busy_resp got=%0b exp=1", busy); end
        complete();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL misalign_busy_after got=%0b exp=0", busy); end
    endtask

    task automatic test_range();
        logic [31:0] addrs [3];
        int lat;
        addrs = '{32'd60, 32'd64, 32'h8000_0000};
        for (int i = 0; i < 3; i++) begin
            issue(addrs[i], lat);
            checks++; if (lat !== (model_err(addrs[i]) ? 1 : 5)) begin errors++; $display("FAIL range_latency addr=%08h got=%0d", addrs[i], lat); end
            checks++; if (resp_error !== model_err(addrs[i])) begin errors++; $display("FAIL range_err addr=%08h got=%0b exp=%0b", addrs[i], resp_error, model_err(addrs[i])); end
            checks++; if (resp_instruction !== model_word(addrs[i])) begin errors++; $display("FAIL range_instr addr=%08h got=%08h exp=%08h", addrs[i], resp_instruction, model_word(addrs[i])); end
            complete();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] exp_word;
        exp_word = model_word(32'd8);
        issue(32'd8, lat);
        req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (resp_valid !== 1'b1 || resp_instruction !== exp_word || resp_error !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d valid=%0b instr=%08h err=%0b rdy=%0b exp instr=%08h", c, resp_valid, resp_instruction, resp_error, req_ready, exp_word);
            end
        end
        req_valid = 1'b0;
        complete();
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL backpressure_release busy=%0b valid=%0b exp 0 0", busy, resp_valid); end
        $display("backpressure addr=8 word=%08h", exp_word);
    endtask

    task automatic test_collision();
        int lat;
        req_address  = 32'd0;
        req_valid    = 1'b1;
        load_en      = 1'b1;
        load_address = 6'd3;
        load_byte    = 8'hFF;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL collision_ready got=%0b exp=0", req_ready); end
        step();
        load_en      = 1'b0;
        mem_model[3] = 8'hFF;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL collision_accept got=%0b exp=1", req_ready); end
        step();
        req_valid = 1'b0;
        step();
        load_en      = 1'b1;
        load_address = 6'd0;
        load_byte    = 8'hAA;
        step();
        load_en = 1'b0;
        lat = 3;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
        checks++; if (lat !== 5) begin errors++; $display("FAIL collision_latency got=%0d exp=5", lat); end
        checks++; if (resp_instruction !== 32'h200800FF) begin errors++; $display("FAIL collision_instr got=%08h exp=200800ff", resp_instruction); end
        $display("collision instr=%08h", resp_instruction);
        complete();
    endtask

    task automatic test_reset_mid_fetch();
        int lat;
        int seen;
        req_address = 32'd0;
        req_valid   = 1'b1;
        #1;
        step();
        req_valid = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        step();
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_state valid=%0b busy=%0b exp 0 0", resp_valid, busy); end
        checks++; if (resp_instruction !== 32'h0 || resp_error !== 1'b0) begin errors++; $display("FAIL midreset_outputs instr=%08h err=%0b exp 0 0", resp_instruction, resp_error); end
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (resp_valid || busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_response got=%0d active cycles exp=0", seen); end
        issue(32'd0, lat);
        checks++; if (resp_instruction !== 32'h200800FF || lat !== 5) begin errors++; $display("FAIL midreset_refetch instr=%08h lat=%0d exp 200800ff 5", resp_instruction, lat); end
        complete();
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                load(6'($urandom_range(0, 63)), 8'($urandom));
            end else begin
                case ($urandom_range(0, 3))
                    0:       a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
                    1:       a = 32'd64 + 32'($urandom_range(0, 1000)) * 4;
                    default: a = 32'($urandom_range(0, 15)) * 4;
                endcase
                issue(a, lat);
                checks++;
                if (lat !== (model_err(a) ? 1 : 5) || resp_error !== model_err(a) || resp_instruction !== model_word(a)) begin
                    errors++;
                    $display("FAIL random_fetch addr=%08h lat=%0d err=%0b instr=%08h exp err=%0b instr=%08h", a, lat, resp_error, resp_instruction, model_err(a), model_word(a));
                end
                repeat ($urandom_range(0, 2)) step();
                complete();
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL random_idle addr=%08h busy=%0b exp=0", a, busy); end
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_address  = 32'h0;
        resp_ready   = 1'b0;
        load_en      = 1'b0;
        load_address = 6'd0;
        load_byte    = 8'h0;
        test_reset();
        for (int i = 0; i < 64; i++) load(6'(i), 8'($urandom));
        test_program();
        test_misaligned();
        test_range();
        test_backpressure();
        test_collision();
        test_reset_mid_fetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_responder.md
Name: inst_fetch_responder

Overview:
Responder side of the instruction-fetch interface. It accepts a 32-bit instruction address from the fetch/PC stage and returns the 32-bit instruction word. Storage is a byte-wide instruction memory (64 bytes by default), read one byte per cycle and assembled big-endian (MIPS order). A byte-write load port fills the program before or between fetches.

Parameters:
MEM_BYTES, 64, instruction memory size in bytes; power of two, at least 8.
LOAD_AW, 6, load address width; equals log2(MEM_BYTES).

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
req_valid  in  1  fetch request present
req_ready  out  1  responder can accept a request this cycle
req_address  in  32  byte address of requested instruction
resp_valid  out  1  response word valid
resp_ready  in  1  requester accepts response
resp_instruction  out  32  assembled instruction word
resp_error  out  1  request was misaligned or out of range
load_en  in  1  write load_byte into memory this cycle
load_address  in  LOAD_AW  byte address for load write
load_byte  in  8  data for load write
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (reset_n low at a rising edge):
  - state to IDLE.
  - resp_valid=0, resp_error=0, resp_instruction=32'h0, busy=0.
  - req_ready=0 while reset_n is low.
  - Memory contents are not cleared.
- FSM states: IDLE, READ, RESP.
- IDLE:
  - req_ready = !load_en.
  - Request handshake is req_valid && req_ready at a rising edge; req_address is captured at that edge.
  - If req_address[1:0] != 0, or req_address >= MEM_BYTES (full 32-bit compare): go to RESP with resp_error=1 and resp_instruction=32'h0 (MIPS NOP).
  - Otherwise go to READ with beat=0 and the shift register cleared.
- READ:
  - Lasts exactly 4 cycles, beat 0..3.
  - Each edge: shift = {shift[23:0], mem[addr+beat]}. Memory read is combinational.
  - After beat 3, go to RESP with resp_instruction = the assembled word and resp_error=0.
- RESP:
  - resp_valid=1.
  - resp_instruction and resp_error are held stable until resp_valid && resp_ready at an edge.
  - After that handshake, go to IDLE and drop resp_valid.
- Latency, counted from the request-handshake edge:
  - Valid address: resp_valid is high after the 5th rising edge.
  - Error: resp_valid is high after the 1st rising edge.
- Throughput: no overlap. req_ready is 0 in READ and RESP. Minimum 6 cycles per valid fetch, including the IDLE cycle.
- Load port:
  - Writes mem[load_address] <= load_byte at the edge, only in IDLE.
  - load_en in READ or RESP is ignored (no write). The in-flight word is never corrupted.
  - load_en and req_valid together in IDLE: the load wins and req_ready=0 that cycle. The request is accepted on a later cycle and sees the new byte.
- Reset mid-operation (READ or RESP): the transaction is aborted with no response. Outputs take their reset values at that edge.
- Byte addressing inside READ uses addr[LOAD_AW-1:0]+beat. No wrap occurs, because the range check guarantees addr+3 < MEM_BYTES.

Decomposition:
- Package inst_fetch_pkg:
  - state enum {IDLE, READ, RESP}
  - NOP_WORD = 32'h0000_0000
  - DEFAULT_MEM_BYTES = 64
  - BEATS = 4
- One sub-module, inst_byte_ram: MEM_BYTES x 8 storage, one synchronous write port and one combinational read port. FSM, beat counter, range check and shift register live in the top module.

Test Plan:
- Load a program and fetch in order:
  - Load bytes 0..7 = 20 08 00 05 8C 09 00 04.
  - Request addr 0, resp_ready=1 → resp_valid after 5 edges, instruction 32'h20080005, error 0.
  - Then request addr 4 → 32'h8C090004.
- Misaligned request: addr 32'h2 → resp_valid after 1 edge, error=1, instruction 32'h0, busy drops after the response handshake.
- Range boundary:
  - addr 60 → valid word, error 0.
  - addr 64 → error 1.
  - addr 32'h8000_0000 → error 1.
- Backpressure: hold resp_ready=0 for 3 cycles in RESP → resp_valid, instruction and error stable; req_ready=0 throughout; IDLE reached one edge after resp_ready=1.
- Load/request collision:
  - load_en=1 (addr 3, byte 8'hFF) with req_valid=1 in IDLE → req_ready=0 that cycle.
  - Next cycle the request is accepted and returns 32'h200800FF.
  - A load_en pulse during READ does not alter the word.
- Reset mid-fetch:
  - Drive reset_n=0 during READ beat 2 → next edge: resp_valid=0, busy=0, state IDLE, no response.
  - After release, re-request addr 0 → same 32'h200800FF (memory retained).
